// File: rtl/csa_pkg.sv
// Shared elaboration-time helpers for the pipelined carry-save multi-operand adder.
//   csa_levels(m)     : number of 3:2 reduction levels needed to bring m rows down to 2
//   rows_at(m, level) : number of rows present at the input of the given level
//   out_width(n, m)   : result width n + clog2(m), wide enough for the exact sum of m n-bit operands
package csa_pkg;

    // One 3:2 level: every full group of three rows becomes two, leftovers pass through.
    function automatic int reduce_rows(input int r);
        return (r / 3) * 2 + (r % 3);
    endfunction

    function automatic int rows_at(input int m, input int level);
        int r;
        r = m;
        for (int i = 0; i < level; i++) begin
            if (r > 2) r = reduce_rows(r);
        end
        return r;
    endfunction

    // Bounded loop keeps this a legal constant function; 64 levels is far beyond any real m.
    function automatic int csa_levels(input int m);
        int r;
        int l;
        r = m;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (r > 2) begin
                r = reduce_rows(r);
                l++;
            end
        end
        return l;
    endfunction

    function automatic int out_width(input int n, input int m);
        return n + $clog2(m);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit two-operand adder using a Kogge-Stone parallel-prefix carry network.
//   a, b : addends
//   sum  : (a + b) truncated to N bits; the carry out of the MSB is not needed by the user.
module carry_lookahead_adder #(
    parameter int N = 34
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    // carries[i] is the group generate of bits [i:0], i.e. the carry into bit i+1.
    logic [N-1:0] carries;

    always_comb begin
        logic [N-1:0] g_cur;
        logic [N-1:0] p_cur;
        logic [N-1:0] g_nxt;
        logic [N-1:0] p_nxt;
        g_cur = a & b;
        p_cur = a ^ b;
        for (int d = 1; d < N; d = d * 2) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = d; i < N; i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-d]);
                p_nxt[i] = p_cur[i] & p_cur[i-d];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        carries = g_cur;
    end

    assign sum = a ^ b ^ (carries << 1);

endmodule

// File: rtl/carry_save_adder_stage.sv
// Bit-parallel 3:2 compressor over W-bit rows.
//   a, b, c : three input rows
//   sum     : bitwise a ^ b ^ c
//   carry   : majority(a, b, c) shifted left by one; the bit leaving the MSB is dropped
//             because the enclosing datapath is sized so the true sum never needs it.
module carry_save_adder_stage #(
    parameter int W = 34
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/csa_level_reg.sv
// One registered 3:2 reduction level of the multi-operand tree.
//   clk, rst_n, clear    : clock, async active-low reset, synchronous valid flush
//   in_valid / in_ready  : upstream handshake for the R_IN input rows
//   in_rows              : R_IN rows of W bits, row k = in_rows[k*W +: W]
//   out_valid / out_ready: downstream handshake for the reduced rows
//   out_rows             : reduced rows; 3:2 outputs first (sum, carry per group), leftovers after
module csa_level_reg
    import csa_pkg::*;
#(
    parameter int W    = 34,
    parameter int R_IN = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [R_IN*W-1:0]              in_rows,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [rows_at(R_IN, 1)*W-1:0]  out_rows
);

    localparam int GROUPS = R_IN / 3;
    localparam int LEFT   = R_IN % 3;
    localparam int R_OUT  = rows_at(R_IN, 1);

    logic [R_OUT*W-1:0] next_rows;

    for (genvar g = 0; g < GROUPS; g++) begin : gen_csa
        carry_save_adder_stage #(.W(W)) u_csa (
            .a     (in_rows[(3*g)*W +: W]),
            .b     (in_rows[(3*g+1)*W +: W]),
            .c     (in_rows[(3*g+2)*W +: W]),
            .sum   (next_rows[(2*g)*W +: W]),
            .carry (next_rows[(2*g+1)*W +: W])
        );
    end

    for (genvar g = 0; g < LEFT; g++) begin : gen_pass
        assign next_rows[(2*GROUPS+g)*W +: W] = in_rows[(3*GROUPS+g)*W +: W];
    end

    // This stage can take new data when empty or when its content leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rows  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_rows <= next_rows;
        end
    end

endmodule

// File: rtl/pipelined_csa_multi_adder.sv
// Pipelined exact sum of M N-bit operands: registered carry-save reduction levels
// followed by a registered carry-lookahead final add. One sum per clock at full rate.
//   clk, rst_n           : clock, async active-low reset
//   clear                : synchronous flush of every in-flight operand/sum
//   in_valid / in_ready  : operand vector handshake, operand k = in_data[k*N +: N]
//   out_valid / out_ready: result handshake
//   out_sum              : exact sum, N + clog2(M) bits, sign- or zero-extended per SIGNED
//
// Handshake: a transfer happens on an edge where valid && ready. Each stage k has
// ready_k = !valid_k || ready_{k+1}, with the last stage looking at out_ready, so
// in_ready is a purely combinational chain back from out_ready (no skid storage).
// A stalled stage holds its data and valid; clear beats every transfer.
module pipelined_csa_multi_adder
    import csa_pkg::*;
#(
    parameter int N      = 32,
    parameter int M      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [M*N-1:0]               in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [out_width(N, M)-1:0]   out_sum
);

    localparam int OW  = out_width(N, M);
    localparam int L   = csa_levels(M);
    localparam int EXT = OW - N;

    // Element g carries the rows entering level g; element L feeds the final adder.
    // Rows beyond rows_at(M, g) in an element are unused.
    logic [M*OW-1:0] lvl_rows  [0:L];
    logic            lvl_valid [0:L];
    logic            lvl_ready [0:L];
    logic [OW-1:0]   cla_sum;

    for (genvar k = 0; k < M; k++) begin : gen_ext
        logic [N-1:0] op;
        assign op = in_data[k*N +: N];
        assign lvl_rows[0][k*OW +: OW] = SIGNED ? {{EXT{op[N-1]}}, op} : {{EXT{1'b0}}, op};
    end

    assign lvl_valid[0] = in_valid;
    assign in_ready     = lvl_ready[0];

    for (genvar g = 0; g < L; g++) begin : gen_lvl
        localparam int RI = rows_at(M, g);
        localparam int RO = rows_at(M, g + 1);
        csa_level_reg #(.W(OW), .R_IN(RI)) u_lvl (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (lvl_valid[g]),
            .in_ready  (lvl_ready[g]),
            .in_rows   (lvl_rows[g][RI*OW-1:0]),
            .out_valid (lvl_valid[g+1]),
            .out_ready (lvl_ready[g+1]),
            .out_rows  (lvl_rows[g+1][RO*OW-1:0])
        );
    end

    carry_lookahead_adder #(.N(OW)) u_cla (
        .a   (lvl_rows[L][OW-1:0]),
        .b   (lvl_rows[L][2*OW-1:OW]),
        .sum (cla_sum)
    );

    assign lvl_ready[L] = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (lvl_ready[L]) begin
            out_valid <= lvl_valid[L];
            if (lvl_valid[L]) out_sum <= cla_sum;
        end
    end

endmodule

// File: tb/tb_pipelined_csa_multi_adder.sv
// Directed bench for pipelined_csa_multi_adder. Five configurations share clock, reset,
// clear, in_valid and out_ready; each has its own operand bus and outputs.
//   d0: N=32 M=4 unsigned   d1: N=32 M=4 signed   d2: N=8 M=9 unsigned
//   d3: N=32 M=2 unsigned   d4: N=32 M=2 signed
module tb_pipelined_csa_multi_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clear, in_valid, out_ready;

    logic [127:0] d0_in, d1_in;
    logic [71:0]  d2_in;
    logic [63:0]  d3_in, d4_in;
    logic d0_ir, d1_ir, d2_ir, d3_ir, d4_ir;
    logic d0_ov, d1_ov, d2_ov, d3_ov, d4_ov;
    logic [33:0] d0_sum, d1_sum;
    logic [11:0] d2_sum;
    logic [32:0] d3_sum, d4_sum;

    pipelined_csa_multi_adder #(.N(32), .M(4), .SIGNED(1'b0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d0_ir),
        .in_data(d0_in), .out_valid(d0_ov), .out_ready(out_ready), .out_sum(d0_sum));
    pipelined_csa_multi_adder #(.N(32), .M(4), .SIGNED(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d1_ir),
        .in_data(d1_in), .out_valid(d1_ov), .out_ready(out_ready), .out_sum(d1_sum));
    pipelined_csa_multi_adder #(.N(8), .M(9), .SIGNED(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d2_ir),
        .in_data(d2_in), .out_valid(d2_ov), .out_ready(out_ready), .out_sum(d2_sum));
    pipelined_csa_multi_adder #(.N(32), .M(2), .SIGNED(1'b0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d3_ir),
        .in_data(d3_in), .out_valid(d3_ov), .out_ready(out_ready), .out_sum(d3_sum));
    pipelined_csa_multi_adder #(.N(32), .M(2), .SIGNED(1'b1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d4_ir),
        .in_data(d4_in), .out_valid(d4_ov), .out_ready(out_ready), .out_sum(d4_sum));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q2[$];
    logic [63:0] exp_q3[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain unsigned sum of m n-bit fields.
    function automatic logic [63:0] usum(input logic [127:0] d, input int m, input int n);
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < m; k++) s += 64'((d >> (k * n)) & ((128'd1 << n) - 128'd1));
        return s;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc0, acc3, got0, got3, n_got;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        d0_in = '0; d1_in = '0; d2_in = '0; d3_in = '0; d4_in = '0;

        // Reset state
        #12;
        check("rst_d0_valid", d0_ov, 0);
        check("rst_d0_sum", d0_sum, 0);
        check("rst_d2_valid", d2_ov, 0);
        check("rst_d3_sum", d3_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_d0_ready", d0_ir, 1);
        check("rst_d2_ready", d2_ir, 1);
        check("rst_d3_ready", d3_ir, 1);

        // All-ones operands, exact latency per configuration
        d0_in = {4{32'hFFFF_FFFF}};
        d1_in = {4{32'hFFFF_FFFF}};
        d2_in = {9{8'hFF}};
        d3_in = {2{32'hFFFF_FFFF}};
        d4_in = {2{32'hFFFF_FFFF}};
        in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            in_valid = 1'b0;
            check("lat_d3_valid", d3_ov, c == 1);
            check("lat_d0_valid", d0_ov, c == 3);
            check("lat_d2_valid", d2_ov, c == 5);
            if (c == 1) begin
                check("ones_d3_sum", d3_sum, 33'h1_FFFF_FFFE);
                check("neg1_d4_sum", d4_sum, 33'h1_FFFF_FFFE);
            end
            if (c == 3) begin
                check("ones_d0_sum", d0_sum, 34'h3_FFFF_FFFC);
                check("neg1_d1_sum", d1_sum, 34'h3_FFFF_FFFC);
            end
            if (c == 5) check("ones_d2_sum", d2_sum, 12'h8F7);
        end

        // Signed extremes and mixed-sign vectors
        in_valid = 1'b1;
        d0_in = {32'd7, 32'h8000_0000, 32'hFFFF_FFFD, 32'd5};
        d1_in = {4{32'h7FFF_FFFF}};
        d3_in = {2{32'h8000_0000}};
        d4_in = {2{32'h7FFF_FFFF}};
        tick();
        check("min2_d3_sum", d3_sum, 33'h1_0000_0000);
        check("max_d4_sum", d4_sum, 33'h0_FFFF_FFFE);
        d1_in = {32'd7, 32'h8000_0000, 32'hFFFF_FFFD, 32'd5};
        d4_in = {32'h8000_0000, 32'd1};
        tick();
        in_valid = 1'b0;
        check("mix_d4_sum", d4_sum, 33'h1_8000_0001);
        tick();
        check("mix_d0_sum", d0_sum, 34'h1_8000_0009);
        check("max_d1_sum", d1_sum, 34'h1_FFFF_FFFC);
        tick();
        check("mix_d1_sum", d1_sum, 34'h3_8000_0009);
        repeat (6) tick();

        // Back-to-back random stream on M=9
        n_got = 0;
        for (int c = 0; c < 26; c++) begin
            if (c < 20) begin
                in_valid = 1'b1;
                d2_in = {8'($urandom), 32'($urandom), 32'($urandom)};
                check("s3_ready_d2", d2_ir, 1);
                exp_q2.push_back(usum({56'd0, d2_in}, 9, 8));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("s3_valid_d2", d2_ov, (c >= 4) && (c < 24));
            if (d2_ov) begin
                n_got++;
                if (exp_q2.size() > 0) check("s3_sum_d2", d2_sum, exp_q2.pop_front());
            end
        end
        check("s3_count_d2", n_got, 20);

        // Backpressure: out_ready low for 10 cycles with in_valid high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc0 = 0;
        acc3 = 0;
        for (int i = 0; i < 10; i++) begin
            d0_in = {32'(32'h4000_0000 + i), 32'(32'h3000_0000 + i * 3),
                     32'h2000_0000, 32'(32'h1000_0000 + i * 7)};
            d3_in = {32'(32'hF000_0000 + i), 32'(32'h2000_0000 + i * 5)};
            if (d0_ir) begin
                exp_q0.push_back(usum(d0_in, 4, 32));
                acc0++;
            end
            if (d3_ir) begin
                exp_q3.push_back(usum({64'd0, d3_in}, 2, 32));
                acc3++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted_d0", acc0, 3);
        check("bp_accepted_d3", acc3, 1);
        check("bp_ready_d0", d0_ir, 0);
        check("bp_hold_valid_d0", d0_ov, 1);
        check("bp_hold_sum_d0", d0_sum, exp_q0[0]);
        out_ready = 1'b1;
        got0 = 0;
        got3 = 0;
        for (int c = 0; c < 8; c++) begin
            if (d0_ov) begin
                got0++;
                if (exp_q0.size() > 0) check("bp_order_d0", d0_sum, exp_q0.pop_front());
            end
            if (d3_ov) begin
                got3++;
                if (exp_q3.size() > 0) check("bp_order_d3", d3_sum, exp_q3.pop_front());
            end
            tick();
        end
        check("bp_drained_d0", got0, 3);
        check("bp_drained_d3", got3, 1);

        // clear with two sums in flight (and a third input presented alongside clear)
        in_valid = 1'b1;
        d0_in = {4{32'h11}};
        d3_in = {2{32'h11}};
        tick();
        d0_in = {4{32'h22}};
        tick();
        check("clr_pre_valid_d3", d3_ov, 1);
        clear = 1'b1;
        d0_in = {4{32'h33}};
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_valid_d0", d0_ov, 0);
        check("clr_valid_d3", d3_ov, 0);
        check("clr_ready_d0", d0_ir, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("clr_stale_d0", d0_ov, 0);
            check("clr_stale_d3", d3_ov, 0);
        end

        // Asynchronous reset between edges mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0_in = {4{32'(i + 1)}};
            d3_in = {2{32'(i + 1)}};
            tick();
        end
        check("arst_pre_valid_d0", d0_ov, 1);
        check("arst_pre_sum_d0", d0_sum, 34'd8);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid_d0", d0_ov, 0);
        check("arst_sum_d0", d0_sum, 0);
        check("arst_valid_d3", d3_ov, 0);
        check("arst_sum_d3", d3_sum, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        d0_in = {32'd100, 32'd200, 32'd300, 32'd400};
        d3_in = {32'hDEAD_BEEF, 32'h1234_5678};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("arst_post_sum_d3", d3_sum, 33'h0_F0E2_1567);
        tick();
        check("arst_post_early_d0", d0_ov, 0);
        tick();
        check("arst_post_valid_d0", d0_ov, 1);
        check("arst_post_sum_d0", d0_sum, 34'd1000);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
